alu_arbiter: RTL

Two-requester round-robin arbiter that shares one `alu_4bit` instance. Each requester presents an operand pair and opcode on a valid/ready handshake. The arbiter grants one request per cycle and drives the shared ALU combinationally. It captures `{carry,result}` into a single response register with backpressure, and counts illegal opcodes. It sits between the operation sources and the ALU datapath, and is the only block that drives the ALU inputs.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_4bit.sv | 30 +++
 rtl/alu_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, legality check and response record for the ALU
// arbiter slice.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef struct packed {
        logic       id;
        logic       carry;
        logic [3:0] result;
    } rsp_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU; {carry,result} is the 5-bit result on zero-extended
// operands, illegal opcodes yield zero.
module alu_4bit
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [3:0] result,
    output logic       carry
);

    logic [4:0] wide;

    always_comb begin
        wide = 5'd0;
        case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            default: wide = 5'd0;
        endcase
    end

    assign result = wide[3:0];
    assign carry  = wide[4];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared alu_4bit, with a
// single backpressured response register and a saturating illegal-op counter.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [3:0]       req_A0,
    input  logic [3:0]       req_B0,
    input  logic [2:0]       req_op0,
    input  logic [3:0]       req_A1,
    input  logic [3:0]       req_B1,
    input  logic [2:0]       req_op1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_result,
    output logic             rsp_carry,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic             prio_q;
    logic             rsp_valid_q;
    rsp_t             rsp_q;
    logic [CNT_W-1:0] cnt_q;

    logic       slot_free;
    logic       grant;
    logic       gidx;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_carry;

    assign slot_free = ~rsp_valid_q | rsp_ready;

    // Favoured requester wins when both are valid; reset masks every grant.
    always_comb begin
        grant = 1'b0;
        gidx  = prio_q;
        if (!rst && slot_free) begin
            if (req_valid[prio_q]) begin
                grant = 1'b1;
                gidx  = prio_q;
            end else if (req_valid[~prio_q]) begin
                grant = 1'b1;
                gidx  = ~prio_q;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[gidx] = 1'b1;
        end
    end

    always_comb begin
        alu_a  = 4'd0;
        alu_b  = 4'd0;
        alu_op = OP_ADD;
        if (grant) begin
            alu_a  = gidx ? req_A1  : req_A0;
            alu_b  = gidx ? req_B1  : req_B0;
            alu_op = gidx ? req_op1 : req_op0;
        end
    end

    alu_4bit u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            cnt_q       <= '0;
        end else if (grant) begin
            rsp_q       <= '{id: gidx, carry: alu_carry, result: alu_result};
            rsp_valid_q <= 1'b1;
            prio_q      <= ~gidx;
            if (!is_legal_op(alu_op) && cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_q.id;
    assign rsp_result  = rsp_q.result;
    assign rsp_carry   = rsp_q.carry;
    assign illegal_cnt = cnt_q;

endmodule
